// File: rtl/fp_align_unit.sv
// Mantissa alignment stage for the FP adder: orders two operands by exponent and
// right-shifts the smaller mantissa up to STEP bits per cycle, collecting guard/round/sticky.
module fp_align_unit #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int STEP   = 4,
  localparam int W     = 1 + EXP_W + FRAC_W,
  localparam int M     = FRAC_W + 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign_l,
  output logic             out_sign_s,
  output logic             out_swap,
  output logic [M-1:0]     mant_l,
  output logic [M-1:0]     mant_s,
  output logic [1:0]       o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and the result is held stable until its transfer.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [EXP_W:0] M_C    = (EXP_W+1)'(M);
  localparam logic [EXP_W:0] STEP_C = (EXP_W+1)'(STEP);

  logic [1:0]       r_state;
  logic [EXP_W:0]   r_rem;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign_l;
  logic             r_sign_s;
  logic             r_swap;
  logic [M-1:0]     r_mant_l;
  logic [M-1:0]     r_mant_s;

  logic [EXP_W-1:0] w_ea_fld;
  logic [EXP_W-1:0] w_eb_fld;
  logic [EXP_W-1:0] w_ea;
  logic [EXP_W-1:0] w_eb;
  logic             w_ha;
  logic             w_hb;
  logic [M-1:0]     w_mant_a;
  logic [M-1:0]     w_mant_b;
  logic [M-1:0]     w_mant_small;
  logic [M-1:0]     w_mant_s_ld;
  logic             w_swap;
  logic             w_sat;
  logic             w_in_ready;
  logic             w_accept;
  logic [EXP_W:0]   w_diff;
  logic [EXP_W:0]   w_k;
  logic [M-1:0]     w_mask;
  logic [M-1:0]     w_shifted;
  logic [M-1:0]     w_mant_s_step;
  logic             w_sticky;
  logic             w_last;

  // Denormals use effective exponent 1 with a zero hidden bit.
  assign w_ea_fld = a[W-2 -: EXP_W];
  assign w_eb_fld = b[W-2 -: EXP_W];
  assign w_ha     = |w_ea_fld;
  assign w_hb     = |w_eb_fld;
  assign w_ea     = w_ha ? w_ea_fld : EXP_W'(1);
  assign w_eb     = w_hb ? w_eb_fld : EXP_W'(1);
  assign w_mant_a = {1'b0, w_ha, a[FRAC_W-1:0], 3'b000};
  assign w_mant_b = {1'b0, w_hb, b[FRAC_W-1:0], 3'b000};

  assign w_swap       = w_eb > w_ea;
  assign w_diff       = w_swap ? ({1'b0, w_eb} - {1'b0, w_ea}) : ({1'b0, w_ea} - {1'b0, w_eb});
  assign w_sat        = w_diff >= M_C;
  assign w_mant_small = w_swap ? w_mant_a : w_mant_b;
  assign w_mant_s_ld  = w_sat ? {{(M-1){1'b0}}, |w_mant_small} : w_mant_small;

  assign w_in_ready = ~rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept   = in_valid & w_in_ready;

  // One shift step: move by at most STEP, folding every bit that falls off into bit 0.
  assign w_k = (r_rem < STEP_C) ? r_rem : STEP_C;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < M; i++) begin
      w_mask[i] = (i < int'(w_k));
    end
  end

  assign w_shifted     = r_mant_s >> w_k;
  assign w_sticky      = (|(r_mant_s & w_mask)) | r_mant_s[0];
  assign w_mant_s_step = {w_shifted[M-1:1], w_shifted[0] | w_sticky};
  assign w_last        = (w_k == r_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_exp    <= '0;
      r_sign_l <= 1'b0;
      r_sign_s <= 1'b0;
      r_swap   <= 1'b0;
      r_mant_l <= '0;
      r_mant_s <= '0;
    end else if (w_accept) begin
      r_exp    <= w_swap ? w_eb : w_ea;
      r_sign_l <= w_swap ? b[W-1] : a[W-1];
      r_sign_s <= w_swap ? a[W-1] : b[W-1];
      r_swap   <= w_swap;
      r_mant_l <= w_swap ? w_mant_b : w_mant_a;
      r_mant_s <= w_mant_s_ld;
      r_rem    <= w_diff;
      r_state  <= ((w_diff == '0) || w_sat) ? S_DONE : S_SHIFT;
    end else if (r_state == S_SHIFT) begin
      r_mant_s <= w_mant_s_step;
      r_rem    <= r_rem - w_k;
      if (w_last) begin
        r_state <= S_DONE;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state <= S_IDLE;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state == S_DONE);
  assign out_exp     = r_exp;
  assign out_sign_l  = r_sign_l;
  assign out_sign_s  = r_sign_s;
  assign out_swap    = r_swap;
  assign mant_l      = r_mant_l;
  assign mant_s      = r_mant_s;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fp_align_unit.sv
// Bench for fp_align_unit: directed vectors, randomized pairs against a one-shot
// shift reference model, backpressure, back-to-back streaming and mid-shift reset.
module tb_fp_align_unit;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int STEP   = 4;
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int M      = FRAC_W + 5;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic             sl;
    logic             ss;
    logic             sw;
    logic [M-1:0]     ml;
    logic [M-1:0]     ms;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign_l;
  logic             out_sign_s;
  logic             out_swap;
  logic [M-1:0]     mant_l;
  logic [M-1:0]     mant_s;
  logic [1:0]       dbg_state;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  int   lat_q[$];

  fp_align_unit #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_sign_l(out_sign_l), .out_sign_s(out_sign_s), .out_swap(out_swap),
    .mant_l(mant_l), .mant_s(mant_s), .o_dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference model: align in a single wide shift, sticky = any bit shifted out.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t   r;
    int     ex, ey, d;
    longint mx, my, msm, mlg, smask;
    logic [EXP_W-1:0] fx, fy;
    fx = x[W-2 -: EXP_W];
    fy = y[W-2 -: EXP_W];
    ex = (fx == 0) ? 1 : int'(fx);
    ey = (fy == 0) ? 1 : int'(fy);
    mx = ((fx != 0) ? (longint'(1) << (FRAC_W + 3)) : 64'd0) + (longint'(x[FRAC_W-1:0]) << 3);
    my = ((fy != 0) ? (longint'(1) << (FRAC_W + 3)) : 64'd0) + (longint'(y[FRAC_W-1:0]) << 3);
    r.sw = (ey > ex);
    if (r.sw) begin
      d = ey - ex; mlg = my; msm = mx; r.e = EXP_W'(ey); r.sl = y[W-1]; r.ss = x[W-1];
    end else begin
      d = ex - ey; mlg = mx; msm = my; r.e = EXP_W'(ex); r.sl = x[W-1]; r.ss = y[W-1];
    end
    r.ml = M'(mlg);
    if (d >= M) begin
      r.ms = M'((msm != 0) ? 1 : 0);
    end else begin
      smask = (longint'(1) << d) - 1;
      r.ms  = M'((msm >> d) | (((msm & smask) != 0) ? 64'd1 : 64'd0));
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int ex, ey, d;
    ex = (x[W-2 -: EXP_W] == 0) ? 1 : int'(x[W-2 -: EXP_W]);
    ey = (y[W-2 -: EXP_W] == 0) ? 1 : int'(y[W-2 -: EXP_W]);
    d  = (ex > ey) ? ex - ey : ey - ex;
    if (d == 0 || d >= M) return 1;
    return 1 + (d + STEP - 1) / STEP;
  endfunction

  function automatic res_t got();
    res_t r;
    r.e = out_exp; r.sl = out_sign_l; r.ss = out_sign_s; r.sw = out_swap;
    r.ml = mant_l; r.ms = mant_s;
    return r;
  endfunction

  function automatic logic [W-1:0] mk(input int sgn, input int e, input int frac);
    logic [W-1:0] v;
    v = {1'(sgn), EXP_W'(e), FRAC_W'(frac)};
    return v;
  endfunction

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, output bit ok);
    int n;
    n = 0;
    a = ta; b = tb; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) begin
      exp_q.push_back(model(ta, tb));
      lat_q.push_back(model_lat(ta, tb));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (got() !== res_t'(0)) begin
      failures++; $display("FAIL reset_outputs: got %h expected 0", got());
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0]     va[4];
    logic [W-1:0]     vb[4];
    logic [EXP_W-1:0] ve[4];
    logic             vs[4];
    logic [M-1:0]     vml[4];
    logic [M-1:0]     vms[4];
    int               vl[4];
    int               lat;
    bit               ok;
    va = '{32'h3F800000, 32'h3FC00000, 32'h4B000000, 32'h7F000000};
    vb = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h00000001};
    ve = '{8'h80, 8'h7F, 8'h96, 8'hFE};
    vs = '{1'b1, 1'b0, 1'b0, 1'b0};
    vml = '{28'h4000000, 28'h6000000, 28'h4000000, 28'h4000000};
    vms = '{28'h2000000, 28'h6000000, 28'h0000009, 28'h0000001};
    vl = '{2, 1, 7, 1};
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], ok);
      wait_valid(lat);
      checks++;
      if (!ok || lat != vl[i]) begin
        failures++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, vl[i]);
      end
      checks++;
      if (out_exp !== ve[i] || out_swap !== vs[i]) begin
        failures++;
        $display("FAIL directed%0d_exp_swap: got %h/%b expected %h/%b", i, out_exp, out_swap, ve[i], vs[i]);
      end
      checks++;
      if (mant_l !== vml[i] || mant_s !== vms[i]) begin
        failures++;
        $display("FAIL directed%0d_mant: got %h/%h expected %h/%h", i, mant_l, mant_s, vml[i], vms[i]);
      end
      consume();
    end
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic test_random();
    int           ea, eb, lat, elat;
    logic [W-1:0] ta, tb;
    res_t         e;
    bit           ok;
    for (int n = 0; n < 40; n++) begin
      ea = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) eb = int'($urandom_range(0, 255));
      else eb = ea + int'($urandom_range(0, 70)) - 35;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      ta = mk(int'($urandom_range(0, 1)), ea, int'($urandom));
      tb = mk(int'($urandom_range(0, 1)), eb, int'($urandom));
      send(ta, tb, ok);
      wait_valid(lat);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL random%0d_accept: in_ready never rose", n);
      end else begin
        e = exp_q.pop_front();
        elat = lat_q.pop_front();
        checks++;
        if (lat != elat) begin
          failures++; $display("FAIL random%0d_latency: got %0d expected %0d", n, lat, elat);
        end
        checks++;
        if (got() !== e) begin
          failures++; $display("FAIL random%0d_result a=%h b=%h: got %h expected %h", n, ta, tb, got(), e);
        end
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    res_t old_r, new_r, hold;
    int   lat;
    bit   ok;
    send(32'h3FC00000, 32'h3FC00000, ok);
    wait_valid(lat);
    old_r = exp_q.pop_front();
    void'(lat_q.pop_front());
    hold = got();
    checks++;
    if (hold !== old_r) begin
      failures++; $display("FAIL bp_first_result: got %h expected %h", hold, old_r);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (got() !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got %h v=%b r=%b expected %h v=1 r=0", i, got(), out_valid, in_ready, hold);
      end
    end
    a = 32'hC0400000; b = 32'h40400000; in_valid = 1'b1; out_ready = 1'b1;
    new_r = model(a, b);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || got() !== new_r) begin
      failures++; $display("FAIL bp_no_bubble: got v=%b %h expected v=1 %h", out_valid, got(), new_r);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa[12];
    logic [W-1:0] pb[12];
    int           acc_cyc[12];
    int           idx_in, idx_out, cyc, ea;
    bit           acc;
    res_t         e;
    for (int i = 0; i < 12; i++) begin
      ea = 100;
      pa[i] = mk(int'($urandom_range(0, 1)), ea, int'($urandom));
      pb[i] = mk(int'($urandom_range(0, 1)), ea + int'($urandom_range(0, 30)) - 15, int'($urandom));
    end
    idx_in = 0; idx_out = 0; cyc = 0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (idx_out < 12 && cyc < 500) begin
      if (out_valid) begin
        e = model(pa[idx_out], pb[idx_out]);
        checks++;
        if (got() !== e) begin
          failures++; $display("FAIL b2b%0d_result: got %h expected %h", idx_out, got(), e);
        end
        idx_out++;
      end
      acc = in_valid && in_ready;
      if (acc) acc_cyc[idx_in] = cyc;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx_in++;
        if (idx_in < 12) begin
          a = pa[idx_in]; b = pb[idx_in];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (idx_out != 12) begin
      failures++; $display("FAIL b2b_timeout: got %0d results expected 12", idx_out);
    end else begin
      for (int i = 1; i < 12; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != model_lat(pa[i-1], pb[i-1])) begin
          failures++;
          $display("FAIL b2b%0d_spacing: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1],
                   model_lat(pa[i-1], pb[i-1]));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int   lat, elat;
    res_t e;
    bit   ok;
    send(32'h49800000, 32'h3F800000, ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL rst_mid_in_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || got() !== res_t'(0)) begin
      failures++; $display("FAIL rst_mid_outputs: got v=%b %h expected v=0 0", out_valid, got());
    end
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_ready_after: got %b expected 1", in_ready);
    end
    @(negedge clk);
    send(32'h40A00000, 32'hBF800000, ok);
    wait_valid(lat);
    checks++;
    if (exp_q.size() != 1) begin
      failures++; $display("FAIL rst_mid_fresh_accept: got %0d queued expected 1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      elat = lat_q.pop_front();
      checks++;
      if (got() !== e || lat != elat) begin
        failures++;
        $display("FAIL rst_mid_fresh_result: got %h lat %0d expected %h lat %0d", got(), lat, e, elat);
      end
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
